// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt sequencer: sequence states,
// interrupt causes and the low-byte vector addresses of each cause.
package interrupt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH_PCH,
        ST_PUSH_PCL,
        ST_PUSH_PSR,
        ST_FETCH_LO,
        ST_FETCH_HI
    } seq_state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE,
        CAUSE_RESET,
        CAUSE_NMI,
        CAUSE_BRK,
        CAUSE_IRQ
    } cause_e;

    localparam logic [7:0] VEC_NMI   = 8'hFA;
    localparam logic [7:0] VEC_RESET = 8'hFC;
    localparam logic [7:0] VEC_IRQ   = 8'hFE;

    localparam logic [1:0] PUSH_NONE = 2'd0;
    localparam logic [1:0] PUSH_PCH  = 2'd1;
    localparam logic [1:0] PUSH_PCL  = 2'd2;
    localparam logic [1:0] PUSH_PSR  = 2'd3;

    // BRK shares the IRQ vector; the B bit is what tells them apart.
    function automatic logic [7:0] vector_lo(cause_e cause);
        case (cause)
            CAUSE_NMI:   return VEC_NMI;
            CAUSE_RESET: return VEC_RESET;
            default:     return VEC_IRQ;
        endcase
    endfunction

endpackage

// File: rtl/nmi_edge_latch.sv
// Detects a rising edge on the NMI line and holds it pending until the
// sequencer consumes it.
module nmi_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic nmi,
    input  logic clear,
    output logic pending
);

    logic nmiPrev_q;
    logic pending_q;
    logic pending_d;
    logic nmiEdge;

    assign nmiEdge = nmi & ~nmiPrev_q;

    // A fresh edge wins over a simultaneous clear so a new NMI is never lost.
    always_comb begin
        pending_d = pending_q;
        if (clear) begin
            pending_d = 1'b0;
        end
        if (nmiEdge) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nmiPrev_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            nmiPrev_q <= nmi;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: arbitrates RES/NMI/BRK/IRQ, pushes PC and PSR,
// then fetches the two-byte vector that matches the accepted cause.
module interrupt_sequencer #(
    parameter logic [7:0] VEC_ADH = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       res_req,
    input  logic       nmi,
    input  logic       irq,
    input  logic       brk_req,
    input  logic       irq_mask,
    input  logic       instr_boundary,
    output logic [1:0] push_src,
    output logic       stack_we,
    output logic       sp_dec,
    output logic [7:0] adl_vec,
    output logic [7:0] adh_vec,
    output logic       fetch_lo,
    output logic       fetch_hi,
    output logic       set_i,
    output logic       brk_flag,
    output logic       busy,
    output logic       done
);

    import interrupt_pkg::*;

    seq_state_e state_q, state_d;
    cause_e     cause_q, cause_d;
    logic       brk_q, brk_d;
    logic       nmiPending;
    logic       nmiClear;
    logic       inPush;
    logic       hijackable;

    assign inPush     = (state_q == ST_PUSH_PCH) || (state_q == ST_PUSH_PCL) ||
                        (state_q == ST_PUSH_PSR);
    assign hijackable = (cause_q == CAUSE_IRQ) || (cause_q == CAUSE_BRK);
    assign nmiClear   = (state_q == ST_FETCH_LO) && (cause_q == CAUSE_NMI);

    nmi_edge_latch u_nmi (
        .clk     (clk),
        .rst     (rst),
        .nmi     (nmi),
        .clear   (nmiClear),
        .pending (nmiPending)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cause_q <= CAUSE_NONE;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            brk_q   <= brk_d;
        end
    end

    // brk_q remembers a BRK origin so the pushed B bit survives an NMI hijack.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        brk_d   = brk_q;
        if (state_q == ST_IDLE) begin
            if (res_req) begin
                state_d = ST_PUSH_PCH;
                cause_d = CAUSE_RESET;
                brk_d   = 1'b0;
            end else if (instr_boundary) begin
                if (nmiPending) begin
                    state_d = ST_PUSH_PCH;
                    cause_d = CAUSE_NMI;
                    brk_d   = 1'b0;
                end else if (brk_req) begin
                    state_d = ST_PUSH_PCH;
                    cause_d = CAUSE_BRK;
                    brk_d   = 1'b1;
                end else if (irq && !irq_mask) begin
                    state_d = ST_PUSH_PCH;
                    cause_d = CAUSE_IRQ;
                    brk_d   = 1'b0;
                end
            end
        end else if (res_req) begin
            state_d = ST_PUSH_PCH;
            cause_d = CAUSE_RESET;
            brk_d   = 1'b0;
        end else begin
            if (inPush && nmiPending && hijackable) begin
                cause_d = CAUSE_NMI;
            end
            case (state_q)
                ST_PUSH_PCH: state_d = ST_PUSH_PCL;
                ST_PUSH_PCL: state_d = ST_PUSH_PSR;
                ST_PUSH_PSR: state_d = ST_FETCH_LO;
                ST_FETCH_LO: state_d = ST_FETCH_HI;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        push_src = PUSH_NONE;
        stack_we = 1'b0;
        sp_dec   = 1'b0;
        adl_vec  = 8'h00;
        adh_vec  = 8'h00;
        fetch_lo = 1'b0;
        fetch_hi = 1'b0;
        set_i    = 1'b0;
        brk_flag = 1'b0;
        busy     = (state_q != ST_IDLE);
        done     = 1'b0;
        case (state_q)
            ST_PUSH_PCH: begin
                push_src = PUSH_PCH;
                sp_dec   = 1'b1;
                stack_we = (cause_q != CAUSE_RESET);
            end
            ST_PUSH_PCL: begin
                push_src = PUSH_PCL;
                sp_dec   = 1'b1;
                stack_we = (cause_q != CAUSE_RESET);
            end
            ST_PUSH_PSR: begin
                push_src = PUSH_PSR;
                sp_dec   = 1'b1;
                stack_we = (cause_q != CAUSE_RESET);
                brk_flag = brk_q;
            end
            ST_FETCH_LO: begin
                adl_vec  = vector_lo(cause_q);
                adh_vec  = VEC_ADH;
                fetch_lo = 1'b1;
                set_i    = 1'b1;
            end
            ST_FETCH_HI: begin
                adl_vec  = vector_lo(cause_q) + 8'd1;
                adh_vec  = VEC_ADH;
                fetch_hi = 1'b1;
                done     = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 SHALL have parameter VEC_ADH, default 8'hFF: high byte driven on ADH during vector fetch.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port res_req, input, 1: CPU RES request, level.
REQ-005 SHALL have port nmi, input, 1: NMI line, rising-edge sensitive.
REQ-006 SHALL have port irq, input, 1: IRQ line, level.
REQ-007 SHALL have port brk_req, input, 1: decoder signals BRK opcode, one-cycle pulse.
REQ-008 SHALL have port irq_mask, input, 1: PSR I bit.
REQ-009 SHALL have port instr_boundary, input, 1: high on last cycle of an instruction.
REQ-010 SHALL have port push_src, output, 2: 0 none, 1 PCH, 2 PCL, 3 PSR onto DB/DOR.
REQ-011 SHALL have port stack_we, output, 1: external write strobe for stack push.
REQ-012 SHALL have port sp_dec, output, 1: decrement stack pointer this cycle.
REQ-013 SHALL have port adl_vec, output, 8: ADL preset value (FA/FB/FC/FD/FE/FF) during fetch, else 8'h00.
REQ-014 SHALL have port adh_vec, output, 8: VEC_ADH during fetch, else 8'h00.
REQ-015 SHALL have port fetch_lo / fetch_hi, output, 1 each: load PCL / PCH from external DB.
REQ-016 SHALL have port set_i, output, 1: set PSR I flag.
REQ-017 SHALL have port brk_flag, output, 1: B bit value for pushed PSR.
REQ-018 SHALL have port busy, output, 1: sequence in progress; done, output, 1: one-cycle completion pulse.

Function
REQ-019 SHALL implement states IDLE, PUSH_PCH, PUSH_PCL, PUSH_PSR, FETCH_LO, FETCH_HI; one state per cycle, 5 cycles accept-to-done.
REQ-020 SHALL latch NMI rising edge (nmi 0 then 1 on consecutive clocks) into nmi_pending; held until a NMI sequence reaches FETCH_LO.
REQ-021 SHALL accept in IDLE with priority res_req > nmi_pending > brk_req > (irq & ~irq_mask); NMI/BRK/IRQ accepted only when instr_boundary=1, res_req regardless.
REQ-022 SHALL record cause (RESET, NMI, BRK, IRQ) on acceptance; transition IDLE -> PUSH_PCH.
REQ-023 SHALL in PUSH_* states drive push_src 1/2/3 and sp_dec=1; stack_we=1 except cause RESET (pushes suppressed, sp_dec still 1).
REQ-024 SHALL drive brk_flag=1 in PUSH_PSR only when cause BRK, else 0.
REQ-025 SHALL in FETCH_LO drive adl_vec = FA (NMI), FC (RESET), FE (IRQ/BRK), adh_vec=VEC_ADH, fetch_lo=1, set_i=1.
REQ-026 SHALL in FETCH_HI drive adl_vec = FETCH_LO value + 1, adh_vec=VEC_ADH, fetch_hi=1, done=1; next state IDLE.
REQ-027 SHALL hijack: nmi_pending set while cause is IRQ/BRK in PUSH_* states changes cause to NMI before FETCH_LO; brk_flag in PUSH_PSR keeps original BRK value.
REQ-028 SHALL restart: res_req=1 in any non-IDLE state forces next state PUSH_PCH with cause RESET.
REQ-029 SHALL ignore irq dropped before acceptance; irq held during sequence re-arbitrates only after return to IDLE and next instr_boundary.
REQ-030 SHALL hold busy=1 in all non-IDLE states; all strobes 0 in IDLE.
REQ-031 SHALL keep simultaneous nmi edge and acceptance of NMI from clearing a newer edge arriving after FETCH_LO.

Reset
REQ-032 SHALL on rst=1 at clock edge enter IDLE, clear nmi_pending and cause, clear nmi edge history to 0; all outputs 0 (adl_vec/adh_vec 8'h00).
REQ-033 SHALL give rst precedence over res_req and all other inputs.

Structure
REQ-034 SHALL place state enum, cause enum and vector constants (8'hFA, 8'hFC, 8'hFE) in shared package interrupt_pkg.
REQ-035 SHALL implement NMI edge detection and pending latch in sub-module nmi_edge_latch.

Verification
REQ-036 SHALL test reset: res_req=1 one cycle after rst -> 5 cycles, stack_we never 1, adl_vec FC then FD, adh_vec FF, done in cycle 5.
REQ-037 SHALL test masked IRQ: irq=1, irq_mask=1, instr_boundary=1 -> stays IDLE; clear mask -> push PCH/PCL/PSR with stack_we=1, vector FE/FF, brk_flag=0.
REQ-038 SHALL test BRK vs IRQ: brk_req and irq together at boundary -> cause BRK, brk_flag=1 in PUSH_PSR, vector FE/FF.
REQ-039 SHALL test hijack: IRQ accepted, nmi edge in PUSH_PCL -> fetch FA/FB, nmi_pending cleared after FETCH_LO.
REQ-040 SHALL test restart: res_req pulsed in FETCH_LO of NMI sequence -> next cycle PUSH_PCH, stack_we=0, final vector FC/FD, nmi_pending already clear.
REQ-041 SHALL test NMI edge only: nmi held high 10 cycles -> exactly one NMI sequence.
